feature_load_ctrl: RTL and testbench

Sequencer for the feature-load path of the inference engine. On a start command it breaks one input volume into bus beats, issues read requests tagged with sequence numbers, and owns the `isReadingFeatures`, `isLoadingNextFeatures` and `isLoadingFroze` flags. It drives the per-beat `readPos`/`writeWidth`/`reqSeqF`/`new_params` controls of the ReadFeatures datapath and consumes that datapath's set/reset pulses.

---
 rtl/feature_load_if.sv | 24 ++
 rtl/feature_load_ctrl.sv | 147 ++++++++++++++
 tb/tb_feature_load_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_load_if.sv
// Read-request / read-response bus between the feature-load sequencer and the memory side.
// The master drives requests; the slave returns acceptance and tagged responses.
interface feature_load_if #(
    parameter int ADDR_W = 32,
    parameter int SEQ_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [SEQ_W-1:0]  req_seq;
    logic              rsp_valid;
    logic              rsp_isFeature;
    logic [SEQ_W-1:0]  rsp_seq;

    modport master (
        output req_valid, req_addr, req_seq,
        input  req_ready, rsp_valid, rsp_isFeature, rsp_seq
    );

    modport slave (
        input  req_valid, req_addr, req_seq,
        output req_ready, rsp_valid, rsp_isFeature, rsp_seq
    );
endinterface

// File: rtl/feature_load_ctrl.sv
// Feature-load sequencer: splits one input volume into bus beats, issues tagged reads
// and owns the reading / next-layer / freeze status flags of the ReadFeatures datapath.
module feature_load_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int INPUT_ADDR_W   = 16,
    parameter int SEQ_W          = 4,
    parameter int MAX_READ_WIDTH = 16,
    localparam int RP_W          = $clog2(MAX_READ_WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    start_next,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [INPUT_ADDR_W-1:0] volume_size,
    output logic                    busy,
    output logic                    done,
    feature_load_if.master          bus,
    output logic                    new_params,
    output logic [RP_W-1:0]         readPos,
    output logic [RP_W:0]           writeWidth,
    output logic [SEQ_W-1:0]        reqSeqF,
    output logic                    isReadingFeatures,
    output logic                    isLoadingNextFeatures,
    output logic                    isLoadingFroze,
    input  logic                    dp_resetReading,
    input  logic                    dp_resetLoadingNext,
    input  logic                    dp_setFroze,
    input  logic                    dp_resetFroze
);

    typedef enum logic [2:0] {IDLE, PARAM, ISSUE, WAIT, DRAIN} state_t;

    localparam logic [RP_W:0] MRW = (RP_W+1)'(MAX_READ_WIDTH);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       base_q;
    logic [INPUT_ADDR_W-1:0] volume_q;
    logic [INPUT_ADDR_W:0]   issued_q;
    logic [INPUT_ADDR_W:0]   issued_nxt;
    logic [INPUT_ADDR_W:0]   remaining;
    logic                    start_next_q;
    logic                    done_q;
    logic [ADDR_W-1:0]       cur;
    logic [RP_W:0]           room;
    logic                    accept_start;
    logic                    beat_match;
    logic                    done_d;

    // Beat descriptor derived from the current word address; stable in WAIT since issued only moves on a match.
    always_comb begin
        cur          = base_q + ADDR_W'(issued_q);
        readPos      = cur[RP_W-1:0];
        bus.req_addr = {cur[ADDR_W-1:RP_W], {RP_W{1'b0}}};
        room         = MRW - {1'b0, readPos};
        remaining    = {1'b0, volume_q} - issued_q;
        writeWidth   = (remaining < (INPUT_ADDR_W+1)'(room)) ? remaining[RP_W:0] : room;
        issued_nxt   = issued_q + (INPUT_ADDR_W+1)'(writeWidth);
    end

    always_comb begin
        state_d       = state_q;
        accept_start  = 1'b0;
        beat_match    = 1'b0;
        done_d        = 1'b0;
        bus.req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (volume_size != '0) begin
                        accept_start = 1'b1;
                        state_d      = PARAM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PARAM: state_d = ISSUE;
            ISSUE: begin
                bus.req_valid = ~isLoadingFroze;
                if (~isLoadingFroze && bus.req_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (bus.rsp_valid && bus.rsp_isFeature && bus.rsp_seq == reqSeqF) begin
                    beat_match = 1'b1;
                    state_d    = (issued_nxt >= {1'b0, volume_q}) ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                if (!isReadingFeatures) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat-math registers are cleared too so the descriptor outputs read zero out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q               <= IDLE;
            base_q                <= '0;
            volume_q              <= '0;
            issued_q              <= '0;
            start_next_q          <= 1'b0;
            reqSeqF               <= '0;
            done_q                <= 1'b0;
            isReadingFeatures     <= 1'b0;
            isLoadingNextFeatures <= 1'b0;
            isLoadingFroze        <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept_start) begin
                base_q       <= base_addr;
                volume_q     <= volume_size;
                issued_q     <= '0;
                start_next_q <= start_next;
            end
            if (beat_match) begin
                issued_q <= issued_nxt;
                reqSeqF  <= reqSeqF + 1'b1;
            end
            // Sets take priority over same-cycle clear pulses from the datapath.
            if (state_q == PARAM)
                isReadingFeatures <= 1'b1;
            else if (dp_resetReading)
                isReadingFeatures <= 1'b0;
            if (state_q == PARAM && start_next_q)
                isLoadingNextFeatures <= 1'b1;
            else if (dp_resetLoadingNext)
                isLoadingNextFeatures <= 1'b0;
            if (dp_setFroze)
                isLoadingFroze <= 1'b1;
            else if (dp_resetFroze)
                isLoadingFroze <= 1'b0;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign new_params  = (state_q == PARAM);
    assign bus.req_seq = reqSeqF;

endmodule

// File: tb/tb_feature_load_ctrl.sv
// Directed bench for feature_load_ctrl: dut_a (8-word beats, 4-bit tags) and dut_b (2-bit tags for wrap).
module tb_feature_load_ctrl;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- dut_a ----------------
    logic        a_start, a_start_next, a_busy, a_done, a_new_params;
    logic [31:0] a_base;
    logic [15:0] a_vol;
    logic [2:0]  a_readPos;
    logic [3:0]  a_writeWidth;
    logic [3:0]  a_reqSeqF;
    logic        a_rd, a_nx, a_fz;
    logic        a_rst_rd, a_rst_nx, a_set_fz, a_rst_fz;

    feature_load_if #(.ADDR_W(32), .SEQ_W(4)) ifa();

    feature_load_ctrl #(.ADDR_W(32), .INPUT_ADDR_W(16), .SEQ_W(4), .MAX_READ_WIDTH(8)) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .start_next(a_start_next),
        .base_addr(a_base), .volume_size(a_vol), .busy(a_busy), .done(a_done), .bus(ifa),
        .new_params(a_new_params), .readPos(a_readPos), .writeWidth(a_writeWidth), .reqSeqF(a_reqSeqF),
        .isReadingFeatures(a_rd), .isLoadingNextFeatures(a_nx), .isLoadingFroze(a_fz),
        .dp_resetReading(a_rst_rd), .dp_resetLoadingNext(a_rst_nx),
        .dp_setFroze(a_set_fz), .dp_resetFroze(a_rst_fz)
    );

    // ---------------- dut_b ----------------
    logic        b_start, b_start_next, b_busy, b_done, b_new_params;
    logic [31:0] b_base;
    logic [15:0] b_vol;
    logic [2:0]  b_readPos;
    logic [3:0]  b_writeWidth;
    logic [1:0]  b_reqSeqF;
    logic        b_rd, b_nx, b_fz;
    logic        b_rst_rd, b_rst_nx, b_set_fz, b_rst_fz;

    feature_load_if #(.ADDR_W(32), .SEQ_W(2)) ifb();

    feature_load_ctrl #(.ADDR_W(32), .INPUT_ADDR_W(16), .SEQ_W(2), .MAX_READ_WIDTH(8)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .start_next(b_start_next),
        .base_addr(b_base), .volume_size(b_vol), .busy(b_busy), .done(b_done), .bus(ifb),
        .new_params(b_new_params), .readPos(b_readPos), .writeWidth(b_writeWidth), .reqSeqF(b_reqSeqF),
        .isReadingFeatures(b_rd), .isLoadingNextFeatures(b_nx), .isLoadingFroze(b_fz),
        .dp_resetReading(b_rst_rd), .dp_resetLoadingNext(b_rst_nx),
        .dp_setFroze(b_set_fz), .dp_resetFroze(b_rst_fz)
    );

    // One beat on dut_a: check descriptor in ISSUE, accept, then answer with the matching tag.
    task automatic beat_a(input string tag, input logic [31:0] addr, input logic [2:0] rp,
                          input logic [3:0] ww, input logic [3:0] seq);
        check({tag, "_valid"}, ifa.req_valid, 1);
        check({tag, "_addr"},  ifa.req_addr, addr);
        check({tag, "_rpos"},  a_readPos, rp);
        check({tag, "_width"}, a_writeWidth, ww);
        check({tag, "_seq"},   ifa.req_seq, seq);
        ifa.req_ready = 1'b1;
        @(negedge clock);
        ifa.req_ready = 1'b0;
        check({tag, "_wait"}, ifa.req_valid, 0);
        ifa.rsp_valid = 1'b1; ifa.rsp_isFeature = 1'b1; ifa.rsp_seq = seq;
        @(negedge clock);
        ifa.rsp_valid = 1'b0;
    endtask

    task automatic start_a(input logic [31:0] base, input logic [15:0] vol, input logic nxt);
        a_start = 1'b1; a_start_next = nxt; a_base = base; a_vol = vol;
        @(negedge clock);
        a_start = 1'b0; a_start_next = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_start = 0; a_start_next = 0; a_base = 0; a_vol = 0;
        a_rst_rd = 0; a_rst_nx = 0; a_set_fz = 0; a_rst_fz = 0;
        ifa.req_ready = 0; ifa.rsp_valid = 0; ifa.rsp_isFeature = 0; ifa.rsp_seq = 0;
        b_start = 0; b_start_next = 0; b_base = 0; b_vol = 0;
        b_rst_rd = 0; b_rst_nx = 0; b_set_fz = 0; b_rst_fz = 0;
        ifb.req_ready = 0; ifb.rsp_valid = 0; ifb.rsp_isFeature = 0; ifb.rsp_seq = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_valid", ifa.req_valid, 0);
        check("rst_newp", a_new_params, 0);
        check("rst_flags", {a_rd, a_nx, a_fz}, 0);
        check("rst_desc", {a_readPos, a_writeWidth, a_reqSeqF}, 0);
        check("rst_addr", ifa.req_addr, 0);

        // Unaligned load: base 5, 20 words, 8-word beats
        start_a(32'd5, 16'd20, 1'b0);
        check("u_newp", a_new_params, 1);
        check("u_busy", a_busy, 1);
        check("u_valid_T1", ifa.req_valid, 0);
        @(negedge clock);
        check("u_newp_off", a_new_params, 0);
        check("u_reading", a_rd, 1);
        check("u_next", a_nx, 0);
        beat_a("u_b0", 32'd0,  3'd5, 4'd3, 4'd0);
        beat_a("u_b1", 32'd8,  3'd0, 4'd8, 4'd1);
        beat_a("u_b2", 32'd16, 3'd0, 4'd8, 4'd2);
        beat_a("u_b3", 32'd24, 3'd0, 4'd1, 4'd3);
        check("u_drain_busy", a_busy, 1);
        check("u_drain_valid", ifa.req_valid, 0);
        check("u_seq_end", a_reqSeqF, 4);
        check("u_drain_done", a_done, 0);
        a_rst_rd = 1'b1;
        @(negedge clock);
        a_rst_rd = 1'b0;
        check("u_rd_clr", a_rd, 0);
        check("u_done_early", a_done, 0);
        @(negedge clock);
        check("u_done", a_done, 1);
        check("u_busy_off", a_busy, 0);
        @(negedge clock);
        check("u_done_pulse", a_done, 0);

        // Next-layer load with backpressure, stale responses and freeze: base 16, 12 words
        start_a(32'd16, 16'd12, 1'b1);
        check("n_newp", a_new_params, 1);
        @(negedge clock);
        check("n_next", a_nx, 1);
        check("n_reading", a_rd, 1);
        a_start = 1'b1; a_base = 32'd100; a_vol = 16'd3;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", ifa.req_valid, 1);
            check("bp_addr", ifa.req_addr, 16);
            check("bp_seq", ifa.req_seq, 4);
            @(negedge clock);
        end
        a_start = 1'b0;
        check("bp_width", a_writeWidth, 8);
        ifa.req_ready = 1'b1;
        @(negedge clock);
        ifa.req_ready = 1'b0;
        check("bp_accepted", ifa.req_valid, 0);
        ifa.rsp_valid = 1'b1; ifa.rsp_isFeature = 1'b1; ifa.rsp_seq = 4'd3;
        @(negedge clock);
        check("stale_seq", ifa.req_valid, 0);
        check("stale_width", a_writeWidth, 8);
        ifa.rsp_seq = 4'd4; ifa.rsp_isFeature = 1'b0;
        @(negedge clock);
        check("stale_nonfeat", ifa.req_valid, 0);
        check("stale_seqF", a_reqSeqF, 4);
        ifa.rsp_isFeature = 1'b1;
        @(negedge clock);
        ifa.rsp_valid = 1'b0;
        check("n_b1_valid", ifa.req_valid, 1);
        check("n_b1_addr", ifa.req_addr, 24);
        check("n_b1_width", a_writeWidth, 4);
        check("n_b1_seq", ifa.req_seq, 5);
        a_rst_nx = 1'b1;
        @(negedge clock);
        a_rst_nx = 1'b0;
        check("n_next_clr", a_nx, 0);

        a_set_fz = 1'b1;
        @(negedge clock);
        a_set_fz = 1'b0;
        check("fz_set", a_fz, 1);
        check("fz_valid", ifa.req_valid, 0);
        ifa.req_ready = 1'b1;
        @(negedge clock);
        check("fz_noacc_valid", ifa.req_valid, 0);
        check("fz_noacc_addr", ifa.req_addr, 24);
        ifa.req_ready = 1'b0;
        a_set_fz = 1'b1; a_rst_fz = 1'b1;
        @(negedge clock);
        a_set_fz = 1'b0;
        check("fz_both", a_fz, 1);
        check("fz_both_valid", ifa.req_valid, 0);
        @(negedge clock);
        a_rst_fz = 1'b0;
        check("fz_clr", a_fz, 0);
        check("fz_resume_valid", ifa.req_valid, 1);
        check("fz_resume_addr", ifa.req_addr, 24);
        check("fz_resume_seq", ifa.req_seq, 5);
        ifa.req_ready = 1'b1; a_set_fz = 1'b1;
        @(negedge clock);
        ifa.req_ready = 1'b0; a_set_fz = 1'b0;
        check("fz_acc_froze", a_fz, 1);
        check("fz_acc_busy", a_busy, 1);
        ifa.rsp_valid = 1'b1; ifa.rsp_isFeature = 1'b1; ifa.rsp_seq = 4'd5;
        @(negedge clock);
        ifa.rsp_valid = 1'b0;
        check("fz_acc_seq", a_reqSeqF, 6);
        a_rst_fz = 1'b1;
        @(negedge clock);
        a_rst_fz = 1'b0;
        check("fz_drain_valid", ifa.req_valid, 0);
        check("fz_drain_busy", a_busy, 1);
        a_rst_rd = 1'b1;
        @(negedge clock);
        a_rst_rd = 1'b0;
        @(negedge clock);
        check("n_done", a_done, 1);
        check("n_busy_off", a_busy, 0);

        // Zero-volume start completes immediately with no requests
        start_a(32'd40, 16'd0, 1'b1);
        check("z_done", a_done, 1);
        check("z_busy", a_busy, 0);
        check("z_newp", a_new_params, 0);
        check("z_valid", ifa.req_valid, 0);
        @(negedge clock);
        check("z_done_pulse", a_done, 0);
        check("z_flags", {a_rd, a_nx}, 0);

        // dut_b: six aligned beats with 2-bit tags wrapping 3 -> 0
        b_start = 1'b1; b_base = 32'd0; b_vol = 16'd48;
        @(negedge clock);
        b_start = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            check("w_valid", ifb.req_valid, 1);
            check("w_addr", ifb.req_addr, 32'(8 * i));
            check("w_seq", ifb.req_seq, 64'(i % 4));
            ifb.req_ready = 1'b1;
            @(negedge clock);
            ifb.req_ready = 1'b0;
            ifb.rsp_valid = 1'b1; ifb.rsp_isFeature = 1'b1; ifb.rsp_seq = 2'(i % 4);
            @(negedge clock);
            ifb.rsp_valid = 1'b0;
        end
        check("w_seq_end", b_reqSeqF, 2);
        check("w_drain", ifb.req_valid, 0);
        b_rst_rd = 1'b1;
        @(negedge clock);
        b_rst_rd = 1'b0;
        @(negedge clock);
        check("w_done", b_done, 1);

        // Reset while waiting for a response: base 13, 8 words
        start_a(32'd13, 16'd8, 1'b1);
        @(negedge clock);
        check("r_addr", ifa.req_addr, 8);
        check("r_rpos", a_readPos, 5);
        ifa.req_ready = 1'b1;
        @(negedge clock);
        ifa.req_ready = 1'b0;
        a_set_fz = 1'b1;
        @(negedge clock);
        a_set_fz = 1'b0;
        check("r_pre_busy", a_busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("r_busy", a_busy, 0);
        check("r_valid", ifa.req_valid, 0);
        check("r_flags", {a_rd, a_nx, a_fz}, 0);
        check("r_desc", {a_readPos, a_writeWidth, a_reqSeqF}, 0);
        check("r_addr0", ifa.req_addr, 0);
        ifa.rsp_valid = 1'b1; ifa.rsp_isFeature = 1'b1; ifa.rsp_seq = 4'd6;
        @(negedge clock);
        ifa.rsp_valid = 1'b0;
        check("r_stale_busy", a_busy, 0);
        check("r_stale_done", a_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
